// File: rtl/or_reduce_acc.sv
// or_reduce_acc: accumulates the OR of masked input channels across the beats
// of a frame. The frame result (Y, ANY, COUNT) is presented with a
// valid/ready handshake. The output register reloads back-to-back when a
// result is consumed in the same cycle that a new frame closes.

// Per-channel masking lane: passes the channel through only when it is enabled.
module or_reduce_acc_lane #(
    parameter int N = 8
) (
    input  logic [N-1:0] din,
    input  logic         en,
    output logic [N-1:0] dout
);
    assign dout = en ? din : '0;
endmodule

module or_reduce_acc #(
    parameter int N      = 8,
    parameter int M      = 4,
    parameter int CW     = 8,
    parameter int DPFLAG = 0,
    parameter     GROUP  = "std"
) (
    input  logic           CLK,
    input  logic           RESET_N,
    input  logic [M*N-1:0] IN,
    input  logic [M-1:0]   MASK,
    input  logic           IN_VALID,
    input  logic           IN_LAST,
    output logic           IN_READY,
    output logic [N-1:0]   Y,
    output logic           ANY,
    output logic [CW-1:0]  COUNT,
    output logic           OUT_VALID,
    input  logic           OUT_READY
);
    typedef enum logic {IDLE, ACCUM} state_t;

    localparam logic [CW-1:0] CNT_MAX = '1;

    // There is no data-path cell form of this block; flag the request at elaboration.
    if (DPFLAG == 1) begin : g_dp_warn
        $warning("or_reduce_acc: instance cannot be implemented as a data-path cell");
    end

    state_t              state_q, state_d;
    logic [N-1:0]        acc_q, acc_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [N-1:0]        y_q, y_d;
    logic [CW-1:0]       count_q, count_d;
    logic                ov_q, ov_d;

    logic [M-1:0][N-1:0] lane_m;
    logic [N-1:0]        beat;
    logic [N-1:0]        acc_base;
    logic [CW-1:0]       cnt_base;
    logic [CW-1:0]       cnt_inc;
    logic                accept;

    // One masking lane per input channel.
    for (genvar k = 0; k < M; k++) begin : g_lane
        or_reduce_acc_lane #(.N(N)) u_lane (
            .din  (IN[k*N +: N]),
            .en   (MASK[k]),
            .dout (lane_m[k])
        );
    end

    // Beat value: OR across all masked lanes.
    always_comb begin
        beat = '0;
        for (int i = 0; i < M; i++) beat = beat | lane_m[i];
    end

    // The output slot is free when empty or being drained this cycle.
    assign IN_READY = !ov_q || OUT_READY;
    assign accept   = IN_VALID && IN_READY;

    // IDLE always starts from a clean accumulator, so a first beat counts as 1.
    assign acc_base = (state_q == ACCUM) ? acc_q : '0;
    assign cnt_base = (state_q == ACCUM) ? cnt_q : '0;
    assign cnt_inc  = (cnt_base == CNT_MAX) ? cnt_base : cnt_base + CW'(1);

    // Next-state and datapath updates for the frame FSM and output slot.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        count_d = count_q;
        ov_d    = ov_q && !OUT_READY;
        if (accept) begin
            if (IN_LAST) begin
                y_d     = acc_base | beat;
                count_d = cnt_inc;
                ov_d    = 1'b1;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end else begin
                acc_d   = acc_base | beat;
                cnt_d   = cnt_inc;
                state_d = ACCUM;
            end
        end
    end

    // State registers; reset discards any partial frame and the output slot.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
            count_q <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            count_q <= count_d;
            ov_q    <= ov_d;
        end
    end

    assign Y         = y_q;
    assign ANY       = |y_q;
    assign COUNT     = count_q;
    assign OUT_VALID = ov_q;
endmodule

// File: tb/tb_or_reduce_acc.sv
// Bench for or_reduce_acc: table-driven single-beat frames, directed
// multi-cycle sequences, and a randomized run checked against a frame-level
// reference model. A second instance with CW=2 covers count saturation.
module tb_or_reduce_acc;
    localparam int N = 8;
    localparam int M = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [M*N-1:0] din;
    logic [M-1:0]   mask;
    logic           in_valid, in_last, out_ready;
    logic           in_ready, any_o, out_valid;
    logic [N-1:0]   y;
    logic [7:0]     count;
    logic           s_in_ready, s_any, s_out_valid;
    logic [N-1:0]   s_y;
    logic [1:0]     s_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    or_reduce_acc #(.N(N), .M(M), .CW(8)) dut (
        .CLK(clk), .RESET_N(rst_n), .IN(din), .MASK(mask),
        .IN_VALID(in_valid), .IN_LAST(in_last), .IN_READY(in_ready),
        .Y(y), .ANY(any_o), .COUNT(count), .OUT_VALID(out_valid),
        .OUT_READY(out_ready)
    );

    or_reduce_acc #(.N(N), .M(M), .CW(2)) u_sat (
        .CLK(clk), .RESET_N(rst_n), .IN(din), .MASK(mask),
        .IN_VALID(in_valid), .IN_LAST(in_last), .IN_READY(s_in_ready),
        .Y(s_y), .ANY(s_any), .COUNT(s_count), .OUT_VALID(s_out_valid),
        .OUT_READY(out_ready)
    );

    // Reference model: frame-level bookkeeping with an unbounded beat count.
    logic [N-1:0] m_acc, m_y, m_b;
    int           m_n, m_cnt;
    bit           m_ov, m_take;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_acc = '0; m_n = 0; m_y = '0; m_cnt = 0; m_ov = 0;
        end else begin
            m_take = in_valid && (!m_ov || out_ready);
            m_b = '0;
            for (int k = 0; k < M; k++) if (mask[k]) m_b = m_b | din[k*N +: N];
            if (m_ov && out_ready) m_ov = 0;
            if (m_take) begin
                m_acc = m_acc | m_b;
                m_n++;
                if (in_last) begin
                    m_y = m_acc; m_cnt = m_n; m_ov = 1; m_acc = '0; m_n = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Compare every output of both instances against the model.
    task automatic check_all();
        chk("y", y, m_y);
        chk("any", any_o, |m_y);
        chk("count", count, (m_cnt > 255) ? 255 : m_cnt);
        chk("out_valid", out_valid, m_ov);
        chk("in_ready", in_ready, !m_ov || out_ready);
        chk("sat_count", s_count, (m_cnt > 3) ? 3 : m_cnt);
        chk("sat_y", s_y, m_y);
        chk("sat_out_valid", s_out_valid, m_ov);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive(input logic v, input logic l, input logic [M-1:0] mk,
                         input logic [M*N-1:0] d, input logic r);
        in_valid = v; in_last = l; mask = mk; din = d; out_ready = r;
    endtask

    typedef struct {
        logic [M-1:0]   mk;
        logic [M*N-1:0] d;
        logic [N-1:0]   y;
        logic           any;
    } vec_t;
    vec_t tbl[5];

    // Channel 0 = 8'h01, channel 1 = 8'h02, channel 2 = 8'h04, channel 3 = 8'h08.
    localparam logic [M*N-1:0] IN_A = 32'h0804_0201;

    initial begin
        tbl[0] = '{4'b1111, IN_A, 8'h0F, 1'b1};
        tbl[1] = '{4'b0101, IN_A, 8'h05, 1'b1};
        tbl[2] = '{4'b0000, IN_A, 8'h00, 1'b0};
        tbl[3] = '{4'b1000, 32'hA500_0000, 8'hA5, 1'b1};
        tbl[4] = '{4'b0110, 32'h00F0_0F00, 8'hFF, 1'b1};

        rst_n = 1'b0;
        drive(0, 0, '0, '0, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_y", y, 8'h00);
        chk("reset_count", count, 8'd0);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-beat frames from the table.
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, tbl[i].mk, tbl[i].d, 1);
            cycle();
            chk("tbl_y", y, tbl[i].y);
            chk("tbl_any", any_o, tbl[i].any);
            chk("tbl_count", count, 8'd1);
            chk("tbl_out_valid", out_valid, 1'b1);
            drive(0, 0, '0, '0, 1);
            cycle();
            chk("tbl_drain", out_valid, 1'b0);
        end

        // Three-beat frame: exactly one result pulse.
        drive(1, 0, 4'b0001, 32'h10, 1); cycle();
        chk("mb_ov1", out_valid, 1'b0);
        drive(1, 0, 4'b0001, 32'h20, 1); cycle();
        chk("mb_ov2", out_valid, 1'b0);
        drive(1, 1, 4'b0001, 32'h80, 1); cycle();
        chk("mb_y", y, 8'hB0);
        chk("mb_count", count, 8'd3);
        chk("mb_ov3", out_valid, 1'b1);
        drive(0, 0, '0, '0, 1); cycle();
        chk("mb_ov4", out_valid, 1'b0);

        // Backpressure: result held while a second frame waits, then no bubble.
        drive(1, 1, 4'b0001, 32'h3C, 0); cycle();
        chk("bp_y0", y, 8'h3C);
        drive(1, 1, 4'b0010, 32'h0000_C300, 0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_in_ready", in_ready, 1'b0);
            cycle();
            chk("bp_y_hold", y, 8'h3C);
            chk("bp_count_hold", count, 8'd1);
            chk("bp_ov_hold", out_valid, 1'b1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_rel", in_ready, 1'b1);
        cycle();
        chk("bp_y1", y, 8'hC3);
        chk("bp_ov_nobubble", out_valid, 1'b1);
        drive(0, 0, '0, '0, 1); cycle();

        // Saturation: 6-beat frame; CW=2 instance must stop at 3.
        for (int i = 0; i < 6; i++) begin
            drive(1, (i == 5), 4'b0001, 32'(1 << i), 1);
            cycle();
        end
        chk("sat_count3", s_count, 2'd3);
        chk("sat_count6", count, 8'd6);
        chk("sat_y3f", y, 8'h3F);
        drive(0, 0, '0, '0, 1); cycle();

        // Async reset mid-frame, with a stale result still in Y/COUNT.
        drive(1, 0, 4'b0001, 32'hF0, 1); cycle();
        drive(1, 0, 4'b0001, 32'h0E, 1); cycle();
        drive(0, 0, '0, '0, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_y", y, 8'h00);
        chk("rst_any", any_o, 1'b0);
        chk("rst_count", count, 8'd0);
        chk("rst_ov", out_valid, 1'b0);
        check_all();
        drive(1, 1, 4'b0001, 32'hFF, 0);
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        cycle();
        chk("rst_no_accept", out_valid, 1'b0);
        drive(0, 0, '0, '0, 1);
        #2;
        rst_n = 1'b1;
        drive(1, 1, 4'b0001, 32'h01, 1); cycle();
        chk("post_rst_y", y, 8'h01);
        chk("post_rst_count", count, 8'd1);
        chk("post_rst_ov", out_valid, 1'b1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3),
                  M'($urandom), $urandom, ($urandom_range(0, 9) < 7));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/or_reduce_acc.md
OR_REDUCE_ACC -- requirements
Module: or_reduce_acc

Interface
REQ-001 Parameters SHALL be as follows, one per line: name, default, meaning.
- N, 8, channel data width in bits (legal range 1..64).
- M, 4, number of input channels (legal range 2..8).
- CW, 8, beat-counter width in bits (legal range 2..16).
- DPFLAG, 0, data-path implementation request; no datapath form exists.
- GROUP, "std", library group tag; no functional effect.

REQ-002 Ports SHALL be as follows, one per line: name, direction, width, meaning.
- CLK, input, 1, single clock; all state updates on the rising edge.
- RESET_N, input, 1, asynchronous active-low reset.
- IN, input, M*N, packed channels; channel k occupies bits [k*N+N-1 : k*N].
- MASK, input, M, per-channel enable; bit k=1 includes channel k.
- IN_VALID, input, 1, a beat is present on IN.
- IN_LAST, input, 1, the current beat closes a frame.
- IN_READY, output, 1, the block accepts the beat this cycle.
- Y, output, N, OR of all masked channels over all beats of the frame.
- ANY, output, 1, reduction-OR of Y.
- COUNT, output, CW, number of beats in the frame, saturating.
- OUT_VALID, output, 1, Y, ANY and COUNT are valid.
- OUT_READY, input, 1, the consumer takes the result this cycle.

REQ-003 Clock and reset SHALL be a single clock, CLK, and a reset, RESET_N, that is asynchronous and active-low.

Function
REQ-004 A beat SHALL be accepted on a rising CLK edge when IN_VALID=1 and IN_READY=1.
REQ-005 The beat value SHALL be the bitwise OR of channels k for which MASK[k]=1; with MASK=0 the beat value SHALL be 0.
REQ-006 MASK SHALL be sampled per accepted beat; a change between beats SHALL affect only subsequent beats.
REQ-007 The FSM SHALL have two states: IDLE (accumulator and counter cleared) and ACCUM (partial frame held).
REQ-008 In IDLE, an accepted non-last beat SHALL load acc=beat and cnt=1, then go to ACCUM.
REQ-009 In ACCUM, an accepted non-last beat SHALL update acc=acc|beat and increment cnt, saturating at 2^CW-1; the state SHALL stay ACCUM.
REQ-010 An accepted last beat in either state SHALL load Y=acc|beat, with acc treated as 0 in IDLE.
REQ-011 On that last beat, COUNT SHALL load sat(cnt+1) and OUT_VALID SHALL be set on the same edge (latency 1 cycle); acc and cnt SHALL clear and the FSM SHALL return to IDLE.
REQ-012 IN_READY SHALL equal !OUT_VALID | OUT_READY and be combinational; non-last beats SHALL also be stalled while OUT_VALID=1 and OUT_READY=0.
REQ-013 When OUT_VALID=1 and OUT_READY=1 with no last beat accepted, OUT_VALID SHALL clear on the next edge.
REQ-014 When OUT_VALID=1 and OUT_READY=1 with a last beat accepted in the same cycle, the output register SHALL reload with the new result and OUT_VALID SHALL stay 1 (full throughput, no bubble).
REQ-015 Y, ANY and COUNT SHALL hold stable while OUT_VALID=1 and OUT_READY=0.
REQ-016 ANY SHALL be derived from the Y register with no added latency.
REQ-017 IN_LAST SHALL be ignored when IN_VALID=0.
REQ-018 A single-beat frame SHALL produce COUNT=1.
REQ-019 COUNT SHALL saturate at 2^CW-1 and SHALL never wrap.
REQ-020 If DPFLAG==1, the block SHALL print a simulation warning at time 0 stating the instance cannot be implemented as a data-path cell; behaviour SHALL be otherwise unchanged.

Reset
REQ-021 RESET_N=0 SHALL immediately, without waiting for a CLK edge, force the following: FSM=IDLE, acc=0, cnt=0, Y=0, ANY=0, COUNT=0, OUT_VALID=0.
REQ-022 During reset IN_READY SHALL read 1, but no beat SHALL be accepted while RESET_N=0.
REQ-023 Reset asserted mid-frame SHALL discard the partial frame; the first beat after reset release SHALL start a new frame.

Verification
REQ-024 The bench SHALL cover the following single-beat scenario: N=8, M=4, MASK=4'b1111, IN={8'h01,8'h02,8'h04,8'h08}, LAST=1, OUT_READY=1 -> next cycle Y=8'h0F, ANY=1, COUNT=1, OUT_VALID=1.
REQ-025 The bench SHALL cover the following masking scenario: MASK=4'b0101 on the same IN, single beat -> Y=8'h05. MASK=0 -> Y=8'h00, ANY=0, COUNT=1.
REQ-026 The bench SHALL cover the following multi-beat scenario: 3 beats with values 8'h10, 8'h20, 8'h80 (last on the third) -> Y=8'hB0, COUNT=3, one OUT_VALID pulse.
REQ-027 The bench SHALL cover the following backpressure scenario: OUT_READY=0 held 5 cycles with a second frame pending -> IN_READY=0, Y/COUNT stable; OUT_READY=1 -> the second frame completes back-to-back with no bubble.
REQ-028 The bench SHALL cover the following saturation scenario: CW=2, 6-beat frame -> COUNT=3.
REQ-029 The bench SHALL cover the following reset scenario: RESET_N pulsed low asynchronously after 2 beats of a frame -> all outputs 0 at once; a following 1-beat frame with 8'h01 -> Y=8'h01, COUNT=1.
